// File: rtl/stopwatch_time.sv
// Count-up HH:MM:SS stopwatch core: prescaled one-second tick, run/stop, lap freeze and
// clear-while-stopped; all outputs registered for the HMS display block.
module stopwatch_time #(
   parameter int unsigned TICK_DIV  = 50000000,
   parameter int unsigned MAX_HOURS = 23,
   parameter int unsigned WRAP      = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap,
   output logic [4:0] hours,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       running,
   output logic       lap_active,
   output logic       maxed
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);
   localparam logic [4:0] HrsMax = 5'(MAX_HOURS);
   localparam logic [5:0] Sixty1 = 6'd59;
   localparam logic WrapEn = (WRAP != 0);

   typedef enum logic [1:0] {StIdle, StRun, StLap, StStop} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pres_q, pres_d;
   logic [4:0]    live_h_q, live_h_d, snap_h_q, snap_h_d, hours_q, hours_d;
   logic [5:0]    live_m_q, live_m_d, snap_m_q, snap_m_d, mins_q, mins_d;
   logic [5:0]    live_s_q, live_s_d, snap_s_q, snap_s_d, secs_q, secs_d;
   logic          maxed_q, maxed_d;
   logic          running_q, running_d;
   logic          lap_active_q, lap_active_d;

   logic counting, tick, at_limit, stop_at_limit, clear, take_snap;

   always_comb begin
      counting      = (state_q == StRun) || (state_q == StLap);
      tick          = counting && (pres_q == PresLast);
      at_limit      = (live_h_q == HrsMax) && (live_m_q == Sixty1) && (live_s_q == Sixty1);
      stop_at_limit = tick && at_limit && !WrapEn;
      clear         = (state_q == StStop) && !start_stop && lap;
      take_snap     = (state_q == StRun) && !start_stop && !stop_at_limit && lap;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start_stop outranks lap, hitting the limit outranks both
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_stop) state_d = StRun;
         end
         StRun: begin
            if (start_stop || stop_at_limit) state_d = StStop;
            else if (lap)                    state_d = StLap;
         end
         StLap: begin
            if (start_stop || stop_at_limit) state_d = StStop;
            else if (lap)                    state_d = StRun;
         end
         StStop: begin
            if (start_stop) begin
               if (!(maxed_q && !WrapEn)) state_d = StRun;
            end else if (lap) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Prescaler, live time, snapshot and limit flag
   always_comb begin
      pres_d   = pres_q;
      live_h_d = live_h_q;
      live_m_d = live_m_q;
      live_s_d = live_s_q;
      snap_h_d = snap_h_q;
      snap_m_d = snap_m_q;
      snap_s_d = snap_s_q;
      maxed_d  = maxed_q;

      if (counting) begin
         pres_d = (pres_q == PresLast) ? '0 : pres_q + PW'(1);
      end

      if (tick) begin
         if (at_limit) begin
            if (WrapEn) begin
               live_h_d = '0;
               live_m_d = '0;
               live_s_d = '0;
            end
         end else if (live_s_q != Sixty1) begin
            live_s_d = live_s_q + 6'd1;
         end else begin
            live_s_d = '0;
            if (live_m_q != Sixty1) begin
               live_m_d = live_m_q + 6'd1;
            end else begin
               live_m_d = '0;
               live_h_d = live_h_q + 5'd1;
            end
         end
      end

      // Wrap mode flags the rollover for one cycle only; saturate mode holds it
      if (WrapEn) maxed_d = tick && at_limit;
      else        maxed_d = maxed_q || (tick && at_limit);

      // Snapshot takes the value from before this cycle's increment
      if (take_snap) begin
         snap_h_d = live_h_q;
         snap_m_d = live_m_q;
         snap_s_d = live_s_q;
      end

      if (clear) begin
         pres_d   = '0;
         live_h_d = '0;
         live_m_d = '0;
         live_s_d = '0;
         snap_h_d = '0;
         snap_m_d = '0;
         snap_s_d = '0;
         maxed_d  = 1'b0;
      end
   end

   // Output logic, evaluated on the next state so outputs settle one cycle after the cause
   always_comb begin
      running_d    = (state_d == StRun) || (state_d == StLap);
      lap_active_d = (state_d == StLap);
      if (state_d == StLap) begin
         hours_d = snap_h_d;
         mins_d  = snap_m_d;
         secs_d  = snap_s_d;
      end else begin
         hours_d = live_h_d;
         mins_d  = live_m_d;
         secs_d  = live_s_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pres_q       <= '0;
         live_h_q     <= '0;
         live_m_q     <= '0;
         live_s_q     <= '0;
         snap_h_q     <= '0;
         snap_m_q     <= '0;
         snap_s_q     <= '0;
         maxed_q      <= 1'b0;
         hours_q      <= '0;
         mins_q       <= '0;
         secs_q       <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
      end else begin
         pres_q       <= pres_d;
         live_h_q     <= live_h_d;
         live_m_q     <= live_m_d;
         live_s_q     <= live_s_d;
         snap_h_q     <= snap_h_d;
         snap_m_q     <= snap_m_d;
         snap_s_q     <= snap_s_d;
         maxed_q      <= maxed_d;
         hours_q      <= hours_d;
         mins_q       <= mins_d;
         secs_q       <= secs_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
      end
   end

   assign hours      = hours_q;
   assign mins       = mins_q;
   assign secs       = secs_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign maxed      = maxed_q;

   a_lap_implies_run: assert property (@(posedge clk) disable iff (reset)
      lap_active |-> running);
   a_secs_range: assert property (@(posedge clk) disable iff (reset) secs < 6'd60);
   a_mins_range: assert property (@(posedge clk) disable iff (reset) mins < 6'd60);

endmodule

// File: tb/tb_stopwatch_time.sv
// Bench for stopwatch_time: four configurations share one stimulus stream and are checked
// against a model that keeps elapsed time as a plain count of seconds.
module tb_stopwatch_time;

   localparam int N = 4;
   localparam int DIV  [N] = '{4, 2, 2, 2};
   localparam int MAXH [N] = '{23, 0, 0, 23};
   localparam int WRP  [N] = '{0, 0, 1, 0};
   localparam int MIdle = 0, MRun = 1, MLap = 2, MStop = 3;

   logic clk = 1'b0;
   logic reset, start_stop, lap;
   logic [N-1:0][19:0] obs;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic [4:0] h;
      logic [5:0] m, s;
      logic       r, la, mx;
      stopwatch_time #(
         .TICK_DIV (DIV[g]),
         .MAX_HOURS(MAXH[g]),
         .WRAP     (WRP[g])
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .start_stop(start_stop),
         .lap       (lap),
         .hours     (h),
         .mins      (m),
         .secs      (s),
         .running   (r),
         .lap_active(la),
         .maxed     (mx)
      );
      assign obs[g] = {h, m, s, r, la, mx};
   end

   int total = 0;
   int bad = 0;

   // Model state: mode, elapsed seconds, lap snapshot seconds, prescaler phase, limit flag
   int md [N];
   int t  [N];
   int sn [N];
   int ph [N];
   bit mx [N];

   function automatic void mreset(int k);
      md[k] = MIdle; t[k] = 0; sn[k] = 0; ph[k] = 0; mx[k] = 1'b0;
   endfunction

   function automatic void mstep(int k, bit ss, bit lp);
      int lim = MAXH[k] * 3600 + 3599;
      bit cnt = (md[k] == MRun) || (md[k] == MLap);
      bit tick = cnt && (ph[k] == DIV[k] - 1);
      int told = t[k];
      bit forced = 1'b0;
      if (cnt) ph[k] = (ph[k] + 1) % DIV[k];
      if (WRP[k] != 0) mx[k] = 1'b0;
      if (tick) begin
         if (told == lim) begin
            mx[k] = 1'b1;
            if (WRP[k] != 0) t[k] = 0;
            else forced = 1'b1;
         end else begin
            t[k] = told + 1;
         end
      end
      case (md[k])
         MIdle: if (ss) md[k] = MRun;
         MRun: begin
            if (ss || forced) md[k] = MStop;
            else if (lp) begin md[k] = MLap; sn[k] = told; end
         end
         MLap: begin
            if (ss || forced) md[k] = MStop;
            else if (lp) md[k] = MRun;
         end
         default: begin
            if (ss) begin
               if (!(mx[k] && WRP[k] == 0)) md[k] = MRun;
            end else if (lp) begin
               md[k] = MIdle; t[k] = 0; sn[k] = 0; ph[k] = 0; mx[k] = 1'b0;
            end
         end
      endcase
   endfunction

   function automatic logic [19:0] expv(int k);
      int d = (md[k] == MLap) ? sn[k] : t[k];
      return {5'(d / 3600), 6'((d / 60) % 60), 6'(d % 60),
              (md[k] == MRun) || (md[k] == MLap), md[k] == MLap, mx[k]};
   endfunction

   task automatic cyc(input bit ss, input bit lp, input bit rs);
      start_stop = ss;
      lap        = lp;
      reset      = rs;
      @(posedge clk);
      for (int k = 0; k < N; k++) begin
         if (rs) mreset(k);
         else    mstep(k, ss, lp);
      end
      #1;
      start_stop = 1'b0;
      lap        = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic test_reset();
      cyc(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < N; k++) begin
         total++;
         if (obs[k] !== 20'd0) begin
            $display("FAIL reset dut%0d: got %h want %h", k, obs[k], 20'd0);
            bad++;
         end
      end
   endtask

   task automatic test_count();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (40) begin
         cyc(1'b0, 1'b0, 1'b0);
         for (int k = 0; k < N; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               $display("FAIL count dut%0d: got %h want %h", k, obs[k], expv(k));
               bad++;
            end
         end
      end
      total++;
      if (obs[0][8:3] !== 6'd10 || obs[0][14:9] !== 6'd0 || obs[0][2] !== 1'b1) begin
         $display("FAIL count_40 dut0: got s=%0d m=%0d run=%b want s=10 m=0 run=1",
                  obs[0][8:3], obs[0][14:9], obs[0][2]);
         bad++;
      end
      cyc(1'b0, 1'b0, 1'b1);
      for (int k = 0; k < N; k++) begin
         total++;
         if (obs[k] !== 20'd0) begin
            $display("FAIL count_reset dut%0d: got %h want %h", k, obs[k], 20'd0);
            bad++;
         end
      end
   endtask

   task automatic test_lap();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (20) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      total++;
      if (obs[0][8:3] !== 6'd5 || obs[0][1] !== 1'b1) begin
         $display("FAIL lap_freeze dut0: got s=%0d lapact=%b want s=5 lapact=1",
                  obs[0][8:3], obs[0][1]);
         bad++;
      end
      repeat (12) begin
         cyc(1'b0, 1'b0, 1'b0);
         for (int k = 0; k < N; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               $display("FAIL lap_hold dut%0d: got %h want %h", k, obs[k], expv(k));
               bad++;
            end
         end
      end
      cyc(1'b0, 1'b1, 1'b0);
      total++;
      if (obs[0][8:3] !== 6'd8 || obs[0][1] !== 1'b0 || obs[0][2] !== 1'b1) begin
         $display("FAIL lap_release dut0: got s=%0d lapact=%b run=%b want s=8 lapact=0 run=1",
                  obs[0][8:3], obs[0][1], obs[0][2]);
         bad++;
      end
   endtask

   task automatic test_stop_resume();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (28) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (20) begin
         cyc(1'b0, 1'b0, 1'b0);
         for (int k = 0; k < N; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               $display("FAIL stop_hold dut%0d: got %h want %h", k, obs[k], expv(k));
               bad++;
            end
         end
      end
      total++;
      if (obs[0][8:3] !== 6'd7 || obs[0][2] !== 1'b0) begin
         $display("FAIL stop_val dut0: got s=%0d run=%b want s=7 run=0", obs[0][8:3], obs[0][2]);
         bad++;
      end
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      total++;
      if (obs[0][8:3] !== 6'd7) begin
         $display("FAIL resume_partial dut0: got s=%0d want s=7", obs[0][8:3]);
         bad++;
      end
      cyc(1'b0, 1'b0, 1'b0);
      total++;
      if (obs[0][8:3] !== 6'd8) begin
         $display("FAIL resume_tick dut0: got s=%0d want s=8", obs[0][8:3]);
         bad++;
      end
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < N; k++) begin
         total++;
         if (obs[k] !== 20'd0 || obs[k] !== expv(k)) begin
            $display("FAIL clear dut%0d: got %h want %h", k, obs[k], expv(k));
            bad++;
         end
      end
   endtask

   task automatic test_limit();
      int pulses = 0;
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (7250) begin
         cyc(1'b0, 1'b0, 1'b0);
         if (obs[2][0] === 1'b1) pulses++;
         for (int k = 0; k < N; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               $display("FAIL limit_run dut%0d: got %h want %h", k, obs[k], expv(k));
               bad++;
            end
         end
      end
      total++;
      if (obs[1] !== {5'd0, 6'd59, 6'd59, 1'b0, 1'b0, 1'b1}) begin
         $display("FAIL saturate dut1: got %h want %h", obs[1],
                  {5'd0, 6'd59, 6'd59, 1'b0, 1'b0, 1'b1});
         bad++;
      end
      total++;
      if (pulses != 1 || obs[2][2] !== 1'b1) begin
         $display("FAIL wrap_pulse dut2: got pulses=%0d run=%b want pulses=1 run=1",
                  pulses, obs[2][2]);
         bad++;
      end
      total++;
      if (obs[3][19:15] !== 5'd1 || obs[3][14:9] !== 6'd0) begin
         $display("FAIL hour_roll dut3: got h=%0d m=%0d want h=1 m=0",
                  obs[3][19:15], obs[3][14:9]);
         bad++;
      end
      cyc(1'b1, 1'b0, 1'b0);
      total++;
      if (obs[1][2] !== 1'b0 || obs[1][0] !== 1'b1) begin
         $display("FAIL maxed_start dut1: got run=%b maxed=%b want run=0 maxed=1",
                  obs[1][2], obs[1][0]);
         bad++;
      end
      cyc(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < N; k++) begin
         total++;
         if (obs[k] !== expv(k)) begin
            $display("FAIL limit_clear dut%0d: got %h want %h", k, obs[k], expv(k));
            bad++;
         end
      end
   endtask

   task automatic test_simultaneous();
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      repeat (10) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      for (int k = 0; k < N; k++) begin
         total++;
         if (obs[k][2:1] !== 2'b00 || obs[k] !== expv(k)) begin
            $display("FAIL both_pulses dut%0d: got %h want %h", k, obs[k], expv(k));
            bad++;
         end
      end
   endtask

   task automatic test_random();
      cyc(1'b0, 1'b0, 1'b1);
      repeat (3000) begin
         cyc($urandom_range(0, 14) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 499) == 0);
         for (int k = 0; k < N; k++) begin
            total++;
            if (obs[k] !== expv(k)) begin
               $display("FAIL random dut%0d: got %h want %h", k, obs[k], expv(k));
               bad++;
            end
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      start_stop = 1'b0;
      lap        = 1'b0;
      test_reset();
      test_count();
      test_lap();
      test_stop_resume();
      test_limit();
      test_simultaneous();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_time.md
Name: stopwatch_time

Overview:
Count-up HH:MM:SS time core for the stopwatch mode of the timer board, the up-counting counterpart of the countdown time block. Counts elapsed seconds from 0:00:00 on an internal prescaled tick. Supports start/stop, a lap freeze of the displayed value, and clear-while-stopped. Inputs are single-cycle pulses from the existing edge-detector and press-hold blocks; outputs feed the existing HMS display block directly.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second tick (>=2)
MAX_HOURS, 23, highest hours value before the limit
WRAP, 0, 0 = saturate and stop at limit; 1 = wrap to 0:00:00 and keep running

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
reset  input  1  synchronous, active-high; returns block to IDLE, all counts 0
start_stop  input  1  one-cycle pulse; toggles run/stop
lap  input  1  one-cycle pulse; lap freeze/release when running, clear when stopped
hours  output  5  displayed hours (live or lap snapshot)
mins  output  6  displayed minutes 0..59
secs  output  6  displayed seconds 0..59
running  output  1  high in RUNNING or LAP
lap_active  output  1  high in LAP (display frozen)
maxed  output  1  limit indicator (see below)

Behaviour:
- Reset: state IDLE; live and snapshot counters 0; prescaler 0; hours/mins/secs=0; running=0, lap_active=0, maxed=0. Reset overrides all inputs in the same cycle.
- All outputs registered; visible the cycle after the causing edge.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING/LAP; tick when prescaler==TICK_DIV-1 and counting, prescaler wraps to 0. Held (not cleared) in STOPPED so resume keeps partial second; cleared on entry to IDLE.
- Live time on tick: secs+1; secs 59->0 carries mins; mins 59->0 carries hours. Limit = MAX_HOURS:59:59.
- At limit with tick: WRAP=0 -> live time holds at limit, maxed set (sticky until IDLE/reset), state forced to STOPPED. WRAP=1 -> live time 0:00:00, maxed high for exactly one cycle, state unchanged.
- FSM states and transitions (start_stop has priority; lap ignored in any cycle where start_stop=1):
  IDLE: start_stop -> RUNNING; lap ignored.
  RUNNING: start_stop -> STOPPED; lap -> LAP, snapshot <= live time value before this cycle's increment.
  LAP: live time keeps counting; outputs show snapshot; lap -> RUNNING (outputs show live next cycle); start_stop -> STOPPED (outputs show live).
  STOPPED: start_stop -> RUNNING, unless maxed=1 and WRAP=0 (then ignored); lap -> IDLE, live/snapshot/prescaler cleared, maxed cleared.
- Output mux: LAP -> snapshot, else live.
- start_stop with a tick in the same cycle: tick still applied, then state changes.
- Inputs held high multiple cycles are treated as repeated pulses; debouncing is upstream.

Test Plan:
- TICK_DIV=4: reset, start_stop pulse, wait 40 cycles -> secs=10, mins=0, running=1; reset pulse -> all outputs 0, running=0 next cycle.
- Run to 0:00:59, next tick -> 0:01:00; preload near 0:59:59 via long run (TICK_DIV=2) -> rolls to 1:00:00.
- Run to 0:00:05, lap -> outputs freeze at 5, lap_active=1; after 12 more cycles (TICK_DIV=4) lap again -> outputs show 0:00:08.
- Stop at 0:00:07, wait 20 cycles -> unchanged; start_stop -> resumes, next tick after remaining prescaler count gives 8; stop, lap -> 0:00:00, state IDLE.
- MAX_HOURS=0, WRAP=0, TICK_DIV=2: reach 0:59:59, next tick -> holds 0:59:59, maxed=1, running=0; start_stop ignored; lap -> cleared, maxed=0. WRAP=1 -> 0:00:00, maxed one-cycle pulse, running stays 1.
- Simultaneous start_stop and lap in RUNNING -> STOPPED, no snapshot, lap_active=0.
